// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor on the free-running reference clock.
// Define PLL_LOL_COUNT_EN to build the saturating loss-of-lock counter behind lol_cnt.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned TIMER_W       = 20,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             restart,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             fault,
  output logic [1:0]       retry_cnt,
  output logic [CNT_W-1:0] lol_cnt
);

  typedef enum logic [2:0] {
    StResetHold,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  localparam logic [TIMER_W-1:0] RstLast    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LockLast   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] StableLast = TIMER_W'(STABLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         retry_q, retry_d, retry_inc;
  logic               lock_meta_q, lock_s_q;

  // locked comes from the PLL and is asynchronous to refclk.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
    if (restart) begin
      state_d = StResetHold;
      retry_d = 2'd0;
    end else begin
      unique case (state_q)
        StResetHold: begin
          if (timer_q == RstLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          // A lock seen on the timeout cycle still wins.
          if (lock_s_q) begin
            state_d = StStable;
          end else if (timer_q == LockLast) begin
            retry_d = retry_inc;
            state_d = ({30'd0, retry_inc} == MAX_RETRIES) ? StFault : StResetHold;
          end
        end
        StStable: begin
          if (!lock_s_q) begin
            state_d = StWaitLock;
          end else if (timer_q == StableLast) begin
            state_d = StRun;
            retry_d = 2'd0;
          end
        end
        StRun: begin
          if (!lock_s_q) state_d = StResetHold;
        end
        StFault: state_d = StFault;
        default: state_d = StResetHold;
      endcase
    end
    // restart re-arms the hold timer even when already in StResetHold.
    timer_d = (restart || (state_d != state_q)) ? '0 : timer_q + TIMER_W'(1);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q   <= StResetHold;
      timer_q   <= '0;
      retry_q   <= 2'd0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      pll_rst   <= (state_d == StResetHold) || (state_d == StFault);
      sys_rst_n <= (state_d == StRun);
      ready     <= (state_d == StRun);
      fault     <= (state_d == StFault);
    end
  end

  assign retry_cnt = retry_q;

`ifdef PLL_LOL_COUNT_EN
  logic [CNT_W-1:0] lol_q;
  logic             lol_event;

  assign lol_event = !restart && (state_q == StRun) && !lock_s_q;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lol_q <= '0;
    end else if (lol_event && (lol_q != '1)) begin
      lol_q <= lol_q + CNT_W'(1);
    end
  end

  assign lol_cnt = lol_q;
`else
  assign lol_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: vector table plus corner-case sequences.
module tb_pll_lock_sequencer;

  localparam int unsigned CntW = 2;

  logic            refclk;
  logic            rst;
  logic            locked;
  logic            restart;
  logic            pll_rst;
  logic            sys_rst_n;
  logic            ready;
  logic            fault;
  logic [1:0]      retry_cnt;
  logic [CntW-1:0] lol_cnt;

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .TIMER_W      (20),
    .CNT_W        (CntW)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked   (locked),
    .restart  (restart),
    .pll_rst  (pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .lol_cnt  (lol_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic       restart;
    logic       locked;
    int         cycles;
    logic [5:0] exp;  // {pll_rst, sys_rst_n, ready, fault, retry_cnt}
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  int   compared   = 0;
  int   mismatched = 0;
  sb_t  sb_q[$];
  vec_t vecs[12];

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {26'd0, pll_rst, sys_rst_n, ready, fault, retry_cnt};
  endfunction

  function automatic logic [31:0] lol_obs();
    return {30'd0, lol_cnt};
  endfunction

  function automatic logic cur(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return sys_rst_n;
      default: return ready;
    endcase
  endfunction

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_cmp(input logic [31:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      cmp("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      cmp(e.name, act, e.exp);
    end
  endtask

  task automatic wait_sig(input string name, input int sel, input logic val, input int limit,
                          output int n);
    n = 0;
    while (cur(sel) !== val && n < limit) begin
      tick(1);
      n++;
    end
    if (cur(sel) !== val) cmp({name, "_timeout"}, {31'd0, cur(sel)}, {31'd0, val});
  endtask

  // Leaves the bench 1 time unit after an edge with rst just released.
  task automatic do_reset(input logic lock_level);
    rst     = 1'b0;
    restart = 1'b0;
    locked  = lock_level;
    tick(2);
    cmp("reset_outputs", obs(), 32'b100000);
    cmp("reset_lol", lol_obs(), 32'd0);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] next_lol(input logic [31:0] v);
`ifdef PLL_LOL_COUNT_EN
    return (v == 32'd3) ? 32'd3 : v + 32'd1;
`else
    return 32'd0 & v;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int first;
    int rehold;
    logic [31:0] exp_lol;

    rst     = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;

    // Timeout-to-fault and restart, locked held low throughout.
    vecs[0]  = '{1'b0, 1'b0, 3,  6'b100000};
    vecs[1]  = '{1'b0, 1'b0, 1,  6'b000000};
    vecs[2]  = '{1'b0, 1'b0, 31, 6'b000000};
    vecs[3]  = '{1'b0, 1'b0, 1,  6'b100001};
    vecs[4]  = '{1'b0, 1'b0, 3,  6'b100001};
    vecs[5]  = '{1'b0, 1'b0, 1,  6'b000001};
    vecs[6]  = '{1'b0, 1'b0, 31, 6'b000001};
    vecs[7]  = '{1'b0, 1'b0, 1,  6'b100110};
    vecs[8]  = '{1'b0, 1'b0, 20, 6'b100110};
    vecs[9]  = '{1'b1, 1'b0, 1,  6'b100000};
    vecs[10] = '{1'b0, 1'b0, 3,  6'b100000};
    vecs[11] = '{1'b0, 1'b0, 1,  6'b000000};

    do_reset(1'b0);
    foreach (vecs[i]) begin
      restart = vecs[i].restart;
      locked  = vecs[i].locked;
      sb_push($sformatf("vec%0d", i), {26'd0, vecs[i].exp});
      tick(1);
      restart = 1'b0;
      tick(vecs[i].cycles - 1);
      sb_pop_cmp(obs());
    end

    // Nominal power-up, lock sampled on the 5th edge after pll_rst falls.
    do_reset(1'b0);
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    cmp("nom_hold_len", n, 4);
    first = -1;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (c == 4) locked = 1'b1;
      if (ready === 1'b1 && first < 0) first = c;
    end
    cmp("nom_ready_latency", first, 15);
    cmp("nom_run_outputs", obs(), 32'b011000);

    // Loss of lock in RUN.
    locked = 1'b0;
    wait_sig("lol_sysrst", 1, 1'b0, 10, n);
    cmp("lol_sysrst_delay", n, 3);
    cmp("lol_ready_low", {31'd0, ready}, 32'd0);
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    cmp("lol_hold_len", n, 4);
    cmp("lol_count", lol_obs(), next_lol(32'd0));

    // Glitch while STABLE: STABLE entered at edge 5, RUN would be edge 13.
    do_reset(1'b1);
    first  = -1;
    rehold = 0;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (c == 8) locked = 1'b0;
      if (c == 11) locked = 1'b1;
      if (c >= 4 && pll_rst === 1'b1) rehold = 1;
      if (ready === 1'b1 && first < 0) first = c;
    end
    cmp("glitch_ready_edge", first, 22);
    cmp("glitch_no_rehold", rehold, 0);
    cmp("glitch_retry", {30'd0, retry_cnt}, 32'd0);

    // Lock and timeout on the same edge (timer_q==31 at edge 36).
    do_reset(1'b0);
    tick(33);
    locked = 1'b1;
    tick(3);
    cmp("lock_beats_timeout", obs(), 32'b000000);
    wait_sig("lock_beats_run", 2, 1'b1, 20, n);
    cmp("lock_beats_run_delay", n, 8);

    // restart on the timeout edge.
    do_reset(1'b0);
    tick(35);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    cmp("restart_vs_timeout", obs(), 32'b100000);
    tick(3);
    cmp("restart_hold_end", obs(), 32'b100000);
    tick(1);
    cmp("restart_wait_lock", obs(), 32'b000000);

    // Asynchronous reset mid-STABLE and mid-RUN.
    do_reset(1'b1);
    tick(7);
    #3;
    rst = 1'b0;
    #1;
    cmp("rst_async_stable", obs(), 32'b100000);
    do_reset(1'b1);
    tick(20);
    cmp("rst_pre_run", {31'd0, ready}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    cmp("rst_async_run", obs(), 32'b100000);

    // Repeated loss of lock drives the 2-bit counter into saturation.
    do_reset(1'b1);
    wait_sig("sat_first_run", 2, 1'b1, 40, n);
    exp_lol = 32'd0;
    for (int k = 0; k < 5; k++) begin
      locked  = 1'b0;
      exp_lol = next_lol(exp_lol);
      sb_push($sformatf("lol_sat%0d", k), exp_lol);
      wait_sig("sat_drop", 1, 1'b0, 10, n);
      sb_pop_cmp(lol_obs());
      locked = 1'b1;
      wait_sig("sat_relock", 2, 1'b1, 40, n);
    end
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    cmp("restart_keeps_lol", lol_obs(), exp_lol);
    cmp("restart_outputs", obs(), 32'b100000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the PLL reset and supervises lock, running on the free-running reference clock.
- After reset, holds the PLL in reset for a fixed time, waits for lock with a timeout, and checks that lock stays stable.
- Then releases a synchronous system reset for the PLL output domains.
- Detects loss of lock and re-sequences; after a bounded number of failed attempts it raises a fault.

Parameters:
- RST_CYCLES, 16: refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 500000: refclk cycles allowed in WAIT_LOCK (10 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synced-lock cycles required before RUN.
- MAX_RETRIES, 3: consecutive lock timeouts that cause FAULT (>=1).
- TIMER_W, 20: shared timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- CNT_W, 8: loss-of-lock counter width.

Ports:
- refclk  in  1  reference clock, free-running, independent of the PLL.
- rst  in  1  asynchronous, active-low reset.
- locked  in  1  PLL lock, asynchronous to refclk.
- restart  in  1  synchronous one-cycle request to re-sequence.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  1  active-low system reset for downstream logic.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  2  consecutive timeout count (saturates at 3).
- lol_cnt  out  CNT_W  loss-of-lock event count (see Optional Feature).

Behaviour:
- Reset values while rst=0:
  - state=RESET_HOLD, timer=0, retry_cnt=0, lol_cnt=0.
  - pll_rst=1, sys_rst_n=0, ready=0, fault=0.
- Lock synchronizer: two-flop chain gives locked_s; 2-cycle latency; both flops reset to 0.
- All outputs are registered and derived from the state register. No combinational path from any input to any output.
- Timer clears on every state change and increments once per cycle otherwise.
- RESET_HOLD:
  - pll_rst=1.
  - When timer==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - locked_s=1: go to STABLE.
  - Else if timer==LOCK_TIMEOUT-1, increment retry_cnt. If the new value == MAX_RETRIES, go to FAULT; otherwise go to RESET_HOLD.
- STABLE:
  - locked_s=0: go to WAIT_LOCK with the timer restarted. No retry increment; this is the glitch-filter path.
  - timer==STABLE_CYCLES-1 with locked_s=1: go to RUN and clear retry_cnt.
- RUN:
  - sys_rst_n=1, ready=1.
  - locked_s=0: go to RESET_HOLD; increment lol_cnt, saturating at all-ones.
  - sys_rst_n falls on the clock edge that enters RESET_HOLD.
- FAULT:
  - pll_rst=1 (PLL parked in reset), sys_rst_n=0, fault=1.
  - Leaves only on restart or rst.
- restart=1 in any state:
  - Go to RESET_HOLD and clear retry_cnt and fault. lol_cnt is not changed.
  - restart has priority over every lock event and timeout in the same cycle.
  - restart in RESET_HOLD restarts the hold timer.
- Simultaneous events in WAIT_LOCK: if locked_s rises in the same cycle as the timeout, lock wins and the state goes to STABLE.
- Reset mid-operation: asserting rst forces the reset values asynchronously. sys_rst_n drops immediately, without waiting for refclk.
- Power-up latency to ready, with ideal lock arriving k cycles after pll_rst falls: RST_CYCLES + k + 2 + STABLE_CYCLES cycles.

Optional Feature:
- Macro: PLL_LOL_COUNT_EN.
- Defined: lol_cnt is implemented as a saturating counter. It is cleared only by rst.
- Undefined: no counter register is built and lol_cnt is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Bench params: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal: release rst, raise locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready and sys_rst_n rise 15 cycles after pll_rst falls (5+2+8); retry_cnt=0.
- Timeout to fault: locked held 0 -> two WAIT_LOCK windows of 32 cycles separated by a 4-cycle pll_rst pulse; retry_cnt goes 1 then 2; fault=1 and pll_rst=1 held; restart pulse -> fault=0, retry_cnt=0, new 4-cycle hold.
- Glitch in STABLE: locked low for 3 cycles after 4 stable cycles -> back to WAIT_LOCK; ready is not asserted; once locked is held, RUN is reached 8 synced cycles later; retry_cnt unchanged.
- Loss of lock in RUN: drop locked -> sys_rst_n=0 and ready=0 within 3 cycles; pll_rst pulses 4 cycles; lol_cnt=1 with PLL_LOL_COUNT_EN defined, 0 without.
- Reset mid-operation and priority:
  - Assert rst during STABLE -> sys_rst_n=0 and pll_rst=1 immediately, before any refclk edge.
  - Assert restart in the same cycle as the timeout -> state is RESET_HOLD and retry_cnt=0.
- lol_cnt saturation: with CNT_W=2, force 5 loss-of-lock events -> lol_cnt stays at 3.
